// File: rtl/t06_move_scheduler.sv
// rtl/t06_move_scheduler.sv - snake move tick scheduler with step/draw handshakes; speed-up feature under T06_SPEEDUP_EN
module t06_move_scheduler #(
    parameter int BASE_PERIOD = 1000000,
    parameter int PERIOD_DEC  = 62500,
    parameter int MIN_PERIOD  = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       apple_eaten,
    input  logic       step_done,
    input  logic       draw_done,
    output logic       step_req,
    output logic       draw_req,
    output logic       busy,
    output logic [2:0] speed_lvl
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TICK = 2'd1,
        S_STEP      = 2'd2,
        S_DRAW      = 2'd3
    } fsm_t;

    localparam logic [1:0] GS_RUN   = 2'b00;
    localparam logic [1:0] GS_START = 2'b01;

    fsm_t        fsm_q, fsm_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] period_q, period_d;
    logic [23:0] period_calc;
    logic [2:0]  speed_q, speed_d;
    logic        step_req_q, step_req_d;
    logic        draw_req_q, draw_req_d;
    logic        busy_q, busy_d;

`ifdef T06_SPEEDUP_EN
    logic [31:0] dec;

    // Period for the current speed level, clamped at MIN_PERIOD without ever subtracting past it
    always_comb begin
        dec = 32'(speed_q) * 32'(PERIOD_DEC);
        if (dec >= 32'(BASE_PERIOD - MIN_PERIOD)) begin
            period_calc = 24'(MIN_PERIOD);
        end else begin
            period_calc = 24'(32'(BASE_PERIOD) - dec);
        end
    end

    // Speed level: new game clears it (wins over apple), apples bump it up to 7
    always_comb begin
        speed_d = speed_q;
        if (state == GS_START) begin
            speed_d = 3'd0;
        end else if (apple_eaten && (speed_q != 3'd7)) begin
            speed_d = speed_q + 3'd1;
        end
    end
`else
    logic unused_apple;
    assign unused_apple = apple_eaten;
    assign period_calc  = 24'(BASE_PERIOD);
    assign speed_d      = 3'd0;
`endif

    // Next-state logic: tick counting, handshakes, and period latch on each WAIT_TICK entry
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        case (fsm_q)
            S_IDLE: begin
                cnt_d = 24'd0;
                if (state == GS_RUN) begin
                    fsm_d    = S_WAIT_TICK;
                    period_d = period_calc;
                end
            end
            S_WAIT_TICK: begin
                if (state != GS_RUN) begin
                    fsm_d = S_IDLE;
                    cnt_d = 24'd0;
                end else if (cnt_q == period_q - 24'd1) begin
                    fsm_d = S_STEP;
                    cnt_d = 24'd0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_STEP: begin
                if (step_done) begin
                    fsm_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (draw_done) begin
                    if (state == GS_RUN) begin
                        fsm_d    = S_WAIT_TICK;
                        period_d = period_calc;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        step_req_d = (fsm_d == S_STEP);
        draw_req_d = (fsm_d == S_DRAW);
        busy_d     = (fsm_d == S_STEP) || (fsm_d == S_DRAW);
    end

    // State and registered Moore outputs; reset aborts any handshake in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            cnt_q      <= 24'd0;
            period_q   <= 24'(BASE_PERIOD);
            speed_q    <= 3'd0;
            step_req_q <= 1'b0;
            draw_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            speed_q    <= speed_d;
            step_req_q <= step_req_d;
            draw_req_q <= draw_req_d;
            busy_q     <= busy_d;
        end
    end

    assign step_req  = step_req_q;
    assign draw_req  = draw_req_q;
    assign busy      = busy_q;
    assign speed_lvl = speed_q;

endmodule

// File: tb/tb_t06_move_scheduler.sv
// tb/tb_t06_move_scheduler.sv - scoreboard bench for t06_move_scheduler (BASE 8, DEC 2, MIN 3)
module tb_t06_move_scheduler;

`ifdef T06_SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state = 2'b01;
    logic       apple_eaten = 1'b0;
    logic       step_done = 1'b1;
    logic       draw_done = 1'b1;
    logic       step_req, draw_req, busy;
    logic [2:0] speed_lvl;

    t06_move_scheduler #(
        .BASE_PERIOD(8),
        .PERIOD_DEC (2),
        .MIN_PERIOD (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .apple_eaten(apple_eaten),
        .step_done  (step_done),
        .draw_done  (draw_done),
        .step_req   (step_req),
        .draw_req   (draw_req),
        .busy       (busy),
        .speed_lvl  (speed_lvl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 step_req, 1 draw_req
        int rise;
        int width;
    } exp_t;
    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int kind, input int rise, input int width);
        exp_t e;
        e.kind = kind; e.rise = rise; e.width = width;
        sb.push_back(e);
    endtask

    task automatic complete(input int kind, input int rise, input int width);
        exp_t e;
        check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("req_kind", kind, e.kind);
            check("req_rise_cycle", rise, e.rise);
            check("req_width", width, e.width);
        end
    endtask

    // Monitor: measure each request pulse and compare against the scoreboard
    logic step_prev = 1'b0, draw_prev = 1'b0;
    int   step_rise = 0, draw_rise = 0;
    always @(negedge clk) begin
        if (step_req || draw_req) check("req_exclusive", int'(step_req && draw_req), 0);
        if (step_req && !step_prev) step_rise = cyc;
        if (!step_req && step_prev) complete(0, step_rise, cyc - step_rise);
        if (draw_req && !draw_prev) draw_rise = cyc;
        if (!draw_req && draw_prev) complete(1, draw_rise, cyc - draw_rise);
        step_prev = step_req;
        draw_prev = draw_req;
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] st);
        @(negedge clk);
        rst = 1'b1; state = st; step_done = 1'b1; draw_done = 1'b1; apple_eaten = 1'b0;
        @(negedge clk);
        check("rst_step_req", int'(step_req), 0);
        check("rst_draw_req", int'(draw_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_speed", int'(speed_lvl), 0);
        rst = 1'b0;
    endtask

    task automatic pulse_apple();
        apple_eaten = 1'b1;
        @(negedge clk);
        apple_eaten = 1'b0;
    endtask

    // From IDLE with state paused: run one tick window and return to IDLE
    task automatic run_window(input int p, input bit mid_pulse);
        int e;
        state = 2'b00;
        e = cyc + 1;
        push(0, e + p, 1);
        push(1, e + p + 1, 1);
        if (mid_pulse) begin
            wait_until(e + 1);
            pulse_apple();
        end
        wait_until(e + p + 1);
        state = 2'b10;
        wait_until(e + p + 4);
    endtask

    initial begin
        int e, e2;

        // Free-running: step every 10 cycles (8 wait + step + draw), each 1 cycle wide
        do_reset(2'b00);
        e = cyc + 1;
        push(0, e + 8, 1);  push(1, e + 9, 1);
        push(0, e + 18, 1); push(1, e + 19, 1);
        wait_until(e + 7);
        check("busy_in_wait", int'(busy), 0);
        wait_until(e + 8);
        check("busy_in_step", int'(busy), 1);
        wait_until(e + 20);
        state = 2'b01;
        wait_until(e + 32);

        // Slow step_done, pause mid-STEP: handshake completes, then IDLE
        do_reset(2'b00);
        step_done = 1'b0;
        e = cyc + 1;
        push(0, e + 8, 5);
        push(1, e + 13, 1);
        wait_until(e + 9);
        state = 2'b10;
        wait_until(e + 12);
        step_done = 1'b1;
        wait_until(e + 30);
        check("busy_after_pause", int'(busy), 0);

        // Speed levels, clamping, mid-window change, new-game clear, saturation
        do_reset(2'b10);
        pulse_apple();
        pulse_apple();
        check("speed_after_2", int'(speed_lvl), SPD ? 2 : 0);
        run_window(SPD ? 4 : 8, 1'b0);
        pulse_apple();
        check("speed_after_3", int'(speed_lvl), SPD ? 3 : 0);
        run_window(SPD ? 3 : 8, 1'b1);
        check("speed_after_mid", int'(speed_lvl), SPD ? 4 : 0);
        state = 2'b01;
        apple_eaten = 1'b1;
        @(negedge clk);
        apple_eaten = 1'b0;
        state = 2'b10;
        check("speed_newgame_clear", int'(speed_lvl), 0);
        for (int i = 0; i < 8; i++) pulse_apple();
        check("speed_saturate", int'(speed_lvl), SPD ? 7 : 0);
        run_window(SPD ? 3 : 8, 1'b0);

        // Pause at counter 5 discards the partial tick; resume waits a full period
        do_reset(2'b00);
        e = cyc + 1;
        wait_until(e + 5);
        state = 2'b10;
        wait_until(e + 8);
        check("busy_paused", int'(busy), 0);
        state = 2'b00;
        e2 = e + 9;
        push(0, e2 + 8, 1);
        push(1, e2 + 9, 1);
        wait_until(e2 + 9);
        state = 2'b10;
        wait_until(e2 + 14);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
